execute_stage: RTL and testbench

Execute stage of the five-stage MIPS32 pipeline. Holds the ID/EX pipeline register, applies forwarding to both operands, and runs the ALU. Computes the branch target and destination register, and drives the `*_e` inputs of the memory stage. Contains an optional iterative unsigned multiply/divide unit with HI/LO registers. It requests an upstream stall when an instruction needs HI/LO or the unit while the unit is busy.

---
 rtl/execute_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS32 execute stage: ID/EX register, forwarding, ALU, optional muldiv unit (EXEC_MULDIV_EN)
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_e,
  input  logic        flush_e,
  input  logic        reg_write_d,
  input  logic        mem_to_reg_d,
  input  logic        mem_write_d,
  input  logic        branch_d,
  input  logic        alu_src_d,
  input  logic        reg_dst_d,
  input  logic        j_inst_d,
  input  logic [3:0]  alu_control_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] sign_imm_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [31:0] jump_addr_d,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rd_d,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] result_w,
  input  logic [31:0] alu_out_m,
  output logic        reg_write_e,
  output logic        mem_to_reg_e,
  output logic        mem_write_e,
  output logic        branch_e,
  output logic        j_inst_e,
  output logic [31:0] alu_out_e,
  output logic [31:0] write_data_e,
  output logic [31:0] pc_branch_e,
  output logic [31:0] jump_addr_e,
  output logic [4:0]  write_reg_e,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic        zero_e,
  output logic        stall_req
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_LUI = 4'b1111;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        reg_dst;
    logic        j_inst;
    logic [3:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sign_imm;
    logic [31:0] pc_plus4;
    logic [31:0] jump_addr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  idex_t       idex_q, idex_d;
  logic        hold;
  logic        muldiv_op;
  logic [31:0] srca, srcb, fwd_b, alu_res;
  logic [4:0]  shamt;

`ifdef EXEC_MULDIV_EN
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_MFLO  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic [32:0] mul_sum, div_trial;
  logic [33:0] div_diff;

  assign muldiv_op = (idex_q.alu_control == OP_MULTU) || (idex_q.alu_control == OP_DIVU);
  assign stall_req = (state_q == ST_RUN) &&
                     (muldiv_op || idex_q.alu_control == OP_MFHI || idex_q.alu_control == OP_MFLO);

  // Muldiv sequencer: latch operands on start, one shift-add / restoring step per RUN cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_trial = {acc_hi_q, acc_lo_q[31]};
    div_diff  = {1'b0, div_trial} - {2'b00, opnd_q};
    if (state_q == ST_IDLE) begin
      if (muldiv_op && !flush_e && !stall_e) begin
        state_d  = ST_RUN;
        cnt_d    = 5'd0;
        is_div_d = (idex_q.alu_control == OP_DIVU);
        opnd_d   = srcb;
        acc_hi_d = 32'd0;
        acc_lo_d = srca;
      end
    end else begin
      if (is_div_q) begin
        // A zero divisor never borrows, leaving the dividend in HI and all ones in LO
        if (!div_diff[33]) begin
          acc_hi_d = div_diff[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b1};
        end else begin
          acc_hi_d = div_trial[31:0];
          acc_lo_d = {acc_lo_q[30:0], 1'b0};
        end
      end else begin
        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[31:1]};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = ST_IDLE;
        hi_d    = acc_hi_d;
        lo_d    = acc_lo_d;
      end
    end
  end

  // Muldiv state, working registers and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
    end
  end
`else
  assign muldiv_op = 1'b0;
  assign stall_req = 1'b0;
`endif

  assign hold = stall_e | stall_req;

  // ID/EX next value: flush bubbles, hold keeps, otherwise capture decode
  always_comb begin
    idex_d = idex_q;
    if (flush_e) begin
      idex_d = '0;
    end else if (!hold) begin
      idex_d.reg_write   = reg_write_d;
      idex_d.mem_to_reg  = mem_to_reg_d;
      idex_d.mem_write   = mem_write_d;
      idex_d.branch      = branch_d;
      idex_d.alu_src     = alu_src_d;
      idex_d.reg_dst     = reg_dst_d;
      idex_d.j_inst      = j_inst_d;
      idex_d.alu_control = alu_control_d;
      idex_d.rd1         = rd1_d;
      idex_d.rd2         = rd2_d;
      idex_d.sign_imm    = sign_imm_d;
      idex_d.pc_plus4    = pc_plus4_d;
      idex_d.jump_addr   = jump_addr_d;
      idex_d.rs          = rs_d;
      idex_d.rt          = rt_d;
      idex_d.rd          = rd_d;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  // Operand forwarding and ALU
  always_comb begin
    case (forward_a)
      2'b01:   srca = result_w;
      2'b10:   srca = alu_out_m;
      default: srca = idex_q.rd1;
    endcase
    case (forward_b)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_out_m;
      default: fwd_b = idex_q.rd2;
    endcase
    srcb  = idex_q.alu_src ? idex_q.sign_imm : fwd_b;
    shamt = idex_q.sign_imm[10:6];
    case (idex_q.alu_control)
      OP_AND:  alu_res = srca & srcb;
      OP_OR:   alu_res = srca | srcb;
      OP_ADD:  alu_res = srca + srcb;
      OP_XOR:  alu_res = srca ^ srcb;
      OP_NOR:  alu_res = ~(srca | srcb);
      OP_SUB:  alu_res = srca - srcb;
      OP_SLT:  alu_res = {31'd0, $signed(srca) < $signed(srcb)};
      OP_SLL:  alu_res = srcb << shamt;
      OP_SRL:  alu_res = srcb >> shamt;
      OP_SRA:  alu_res = $signed(srcb) >>> shamt;
      OP_LUI:  alu_res = {srcb[15:0], 16'h0000};
`ifdef EXEC_MULDIV_EN
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
`endif
      default: alu_res = 32'd0;
    endcase
  end

  // A muldiv hazard turns the instruction into a bubble toward the memory stage
  assign reg_write_e  = idex_q.reg_write & ~stall_req & ~muldiv_op;
  assign mem_to_reg_e = idex_q.mem_to_reg & ~stall_req;
  assign mem_write_e  = idex_q.mem_write & ~stall_req;
  assign branch_e     = idex_q.branch & ~stall_req;
  assign j_inst_e     = idex_q.j_inst & ~stall_req;
  assign alu_out_e    = alu_res;
  assign zero_e       = (alu_res == 32'd0);
  assign write_data_e = fwd_b;
  assign pc_branch_e  = idex_q.pc_plus4 + {idex_q.sign_imm[29:0], 2'b00};
  assign jump_addr_e  = idex_q.jump_addr;
  assign write_reg_e  = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
  assign rs_e         = idex_q.rs;
  assign rt_e         = idex_q.rt;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall_e, flush_e;
  logic        reg_write_d, mem_to_reg_d, mem_write_d, branch_d, alu_src_d, reg_dst_d, j_inst_d;
  logic [3:0]  alu_control_d;
  logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d, jump_addr_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] result_w, alu_out_m;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e, j_inst_e;
  logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
  logic [4:0]  write_reg_e, rs_e, rt_e;
  logic        zero_e, stall_req;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .branch_d(branch_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .j_inst_d(j_inst_d),
    .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d),
    .pc_plus4_d(pc_plus4_d), .jump_addr_d(jump_addr_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .forward_a(forward_a), .forward_b(forward_b), .result_w(result_w), .alu_out_m(alu_out_m),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .j_inst_e(j_inst_e), .alu_out_e(alu_out_e), .write_data_e(write_data_e),
    .pc_branch_e(pc_branch_e), .jump_addr_e(jump_addr_e), .write_reg_e(write_reg_e),
    .rs_e(rs_e), .rt_e(rt_e), .zero_e(zero_e), .stall_req(stall_req)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, pc4;
    logic        asrc, rdst;
    logic [4:0]  ctrl;
    logic [1:0]  fa, fb;
    logic [31:0] rw, am;
    logic [4:0]  rt, rd;
    logic [31:0] e_alu, e_wd;
    logic        e_zero;
    logic [4:0]  e_wreg;
    logic [31:0] e_pcb;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  logic [31:0] rq[$];
  vec_t        e;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic set_dec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rw_en, input logic [4:0] rd);
    reg_write_d = rw_en; mem_to_reg_d = 1'b0; mem_write_d = 1'b0; branch_d = 1'b0;
    alu_src_d = 1'b0; reg_dst_d = 1'b1; j_inst_d = 1'b0; alu_control_d = op;
    rd1_d = a; rd2_d = b; sign_imm_d = 32'd0; pc_plus4_d = 32'd0; jump_addr_d = 32'd0;
    rs_d = 5'd0; rt_d = 5'd0; rd_d = rd; forward_a = 2'b00; forward_b = 2'b00;
    result_w = 32'd0; alu_out_m = 32'd0;
  endtask

  task automatic drive(input vec_t v, input int i);
    {reg_write_d, mem_to_reg_d, mem_write_d, branch_d, j_inst_d} = v.ctrl;
    alu_src_d = v.asrc; reg_dst_d = v.rdst; alu_control_d = v.op;
    rd1_d = v.rd1; rd2_d = v.rd2; sign_imm_d = v.imm; pc_plus4_d = v.pc4;
    jump_addr_d = 32'h0040_0000 + 32'(i); rs_d = 5'(i); rt_d = v.rt; rd_d = v.rd;
    forward_a = v.fa; forward_b = v.fb; result_w = v.rw; alu_out_m = v.am;
  endtask

  function automatic logic [31:0] ctrl_out();
    return {27'd0, reg_write_e, mem_to_reg_e, mem_write_e, branch_e, j_inst_e};
  endfunction

  // Runs op a,b; then two HI/LO reads whose results are taken from the scoreboard queue.
  task automatic muldiv_seq(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] r1, input logic [31:0] x1,
                            input logic [3:0] r2, input logic [31:0] x2);
    int n;
    int bad;
    logic [31:0] x;
    set_dec(op, a, b, 1'b0, 5'd0);
    @(posedge clk); #1;
    chk({nm, "_op_alu"}, alu_out_e, 32'd0);
    chk({nm, "_op_stall"}, 32'(stall_req), 32'd0);
    set_dec(r1, 32'd0, 32'd0, 1'b1, 5'd5);
    rq.push_back(x1);
    @(posedge clk); #1;
    set_dec(r2, 32'd0, 32'd0, 1'b1, 5'd6);
    rq.push_back(x2);
    n = 0; bad = 0;
    while (stall_req && n < 40) begin
      n++;
      if (ctrl_out() != 32'd0) bad++;
      @(posedge clk); #1;
    end
    chk({nm, "_stall_cycles"}, 32'(n), 32'd32);
    chk({nm, "_bubble"}, 32'(bad), 32'd0);
    x = rq.pop_front();
    chk({nm, "_read1"}, alu_out_e, x);
    chk({nm, "_read1_rw"}, 32'(reg_write_e), 32'd1);
    @(posedge clk); #1;
    x = rq.pop_front();
    chk({nm, "_read2"}, alu_out_e, x);
    set_dec(4'h0, 32'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    set_dec(4'h2, 32'd7, 32'd5, 1'b1, 5'd3);
    mem_write_d = 1'b1; branch_d = 1'b1; j_inst_d = 1'b1; mem_to_reg_d = 1'b1; pc_plus4_d = 32'h40;
    repeat (2) @(posedge clk); #1;
    chk("rst_alu", alu_out_e, 32'd0);
    chk("rst_zero", 32'(zero_e), 32'd1);
    chk("rst_ctrl", ctrl_out(), 32'd0);
    chk("rst_wreg", 32'(write_reg_e), 32'd0);
    chk("rst_pcb", pc_branch_e, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst = 1'b0;

    //              op     rd1           rd2           imm           pc4      asrc  rdst  ctrl      fa     fb     rw            am            rt  rd  e_alu         e_wd          z     wreg e_pcb
    vecs.push_back('{4'h2, 32'd7,        32'd5,        32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        9,  3,  32'd12,       32'd5,        1'b0, 3,   32'h0});
    vecs.push_back('{4'h6, 32'h55,       32'h55,       32'hFFFFFFFE, 32'h100, 1'b0, 1'b0, 5'b00010, 2'd0, 2'd0, 32'd0,        32'd0,        4,  7,  32'd0,        32'h55,       1'b1, 4,   32'hF8});
    vecs.push_back('{4'h2, 32'd100,      32'd200,      32'd0,        32'h10,  1'b0, 1'b1, 5'b10000, 2'd2, 2'd1, 32'd4,        32'd9,        1,  2,  32'd13,       32'd4,        1'b0, 2,   32'h10});
    vecs.push_back('{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  8,  32'hF000F000, 32'hFF00FF00, 1'b0, 8,   32'h0});
    vecs.push_back('{4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  8,  32'hFFF0FFF0, 32'hFF00FF00, 1'b0, 8,   32'h0});
    vecs.push_back('{4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  8,  32'h0FF00FF0, 32'hFF00FF00, 1'b0, 8,   32'h0});
    vecs.push_back('{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  8,  32'h000F000F, 32'hFF00FF00, 1'b0, 8,   32'h0});
    vecs.push_back('{4'h7, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  10, 32'd1,        32'd1,        1'b0, 10,  32'h0});
    vecs.push_back('{4'h7, 32'd1,        32'hFFFFFFFF, 32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  10, 32'd0,        32'hFFFFFFFF, 1'b1, 10,  32'h0});
    vecs.push_back('{4'h8, 32'd0,        32'd3,        32'h100,      32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  11, 32'h30,       32'd3,        1'b0, 11,  32'h400});
    vecs.push_back('{4'h9, 32'd0,        32'h80000000, 32'h7C0,      32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  12, 32'd1,        32'h80000000, 1'b0, 12,  32'h1F00});
    vecs.push_back('{4'hA, 32'd0,        32'h80000000, 32'h100,      32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  13, 32'hF8000000, 32'h80000000, 1'b0, 13,  32'h400});
    vecs.push_back('{4'hF, 32'd0,        32'hAAAA,     32'h1234,     32'h0,   1'b1, 1'b0, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        6,  14, 32'h12340000, 32'hAAAA,     1'b0, 6,   32'h48D0});
    vecs.push_back('{4'h5, 32'd3,        32'd4,        32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  15, 32'd0,        32'd4,        1'b1, 15,  32'h0});
    vecs.push_back('{4'h2, 32'hFFFFFFFF, 32'd0,        32'd2,        32'h0,   1'b1, 1'b1, 5'b00001, 2'd0, 2'd0, 32'd0,        32'd0,        1,  16, 32'd1,        32'd0,        1'b0, 16,  32'h8});
    vecs.push_back('{4'h2, 32'd1,        32'd2,        32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd3, 2'd3, 32'hBEEF,     32'hDEAD,     1,  17, 32'd3,        32'd2,        1'b0, 17,  32'h0});
    vecs.push_back('{4'h6, 32'd99,       32'd10,       32'd0,        32'h0,   1'b0, 1'b1, 5'b01100, 2'd2, 2'd0, 32'd0,        32'd10,       1,  18, 32'd0,        32'd10,       1'b1, 18,  32'h0});
    vecs.push_back('{4'hB, 32'd0,        32'd21,       32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  19, 32'd0,        32'd21,       1'b1, 19,  32'h0});
    vecs.push_back('{4'hC, 32'd0,        32'd22,       32'd0,        32'h0,   1'b0, 1'b1, 5'b10000, 2'd0, 2'd0, 32'd0,        32'd0,        1,  20, 32'd0,        32'd22,       1'b1, 20,  32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i], i);
      sb.push_back(vecs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_alu", i), alu_out_e, e.e_alu);
      chk($sformatf("v%0d_wd", i), write_data_e, e.e_wd);
      chk($sformatf("v%0d_zero", i), 32'(zero_e), 32'(e.e_zero));
      chk($sformatf("v%0d_wreg", i), 32'(write_reg_e), 32'(e.e_wreg));
      chk($sformatf("v%0d_pcb", i), pc_branch_e, e.e_pcb);
      chk($sformatf("v%0d_ctrl", i), ctrl_out(), 32'(e.ctrl));
      chk($sformatf("v%0d_rs_rt", i), {22'd0, rs_e, rt_e}, {22'd0, 5'(i), e.rt});
      chk($sformatf("v%0d_jump", i), jump_addr_e, 32'h0040_0000 + 32'(i));
      chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'd0);
    end

    // Hold under stall_e, then flush_e together with stall_e clears ID/EX
    set_dec(4'h2, 32'd7, 32'd5, 1'b1, 5'd3);
    @(posedge clk); #1;
    chk("hold_pre_alu", alu_out_e, 32'd12);
    stall_e = 1'b1;
    set_dec(4'h0, 32'd1, 32'd2, 1'b0, 5'd9);
    @(posedge clk); #1;
    chk("hold_alu", alu_out_e, 32'd12);
    chk("hold_wreg", 32'(write_reg_e), 32'd3);
    chk("hold_rw", 32'(reg_write_e), 32'd1);
    flush_e = 1'b1;
    @(posedge clk); #1;
    chk("flush_alu", alu_out_e, 32'd0);
    chk("flush_zero", 32'(zero_e), 32'd1);
    chk("flush_ctrl", ctrl_out(), 32'd0);
    chk("flush_wreg", 32'(write_reg_e), 32'd0);
    stall_e = 1'b0; flush_e = 1'b0;
    set_dec(4'h0, 32'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk); #1;

`ifdef EXEC_MULDIV_EN
    muldiv_seq("multu", 4'hD, 32'hFFFFFFFF, 32'd2, 4'hB, 32'd1, 4'hC, 32'hFFFFFFFE);
    muldiv_seq("divu", 4'hE, 32'd100, 32'd7, 4'hC, 32'd14, 4'hB, 32'd2);
    muldiv_seq("divz", 4'hE, 32'd5, 32'd0, 4'hC, 32'hFFFFFFFF, 4'hB, 32'd5);

    // Reset in the middle of a DIVU discards the result and clears HI
    set_dec(4'hE, 32'd100, 32'd7, 1'b0, 5'd0);
    @(posedge clk); #1;
    set_dec(4'hB, 32'd0, 32'd0, 1'b1, 5'd5);
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    chk("rstmid_busy", 32'(stall_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_stall", 32'(stall_req), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_mfhi", alu_out_e, 32'd0);
    chk("rstmid_stall2", 32'(stall_req), 32'd0);
    bad = 0;
    repeat (34) begin
      @(posedge clk); #1;
      if (alu_out_e != 32'd0 || stall_req) bad++;
    end
    chk("rstmid_discard", 32'(bad), 32'd0);
`else
    set_dec(4'hD, 32'hFFFFFFFF, 32'd2, 1'b0, 5'd0);
    @(posedge clk); #1;
    chk("nomd_multu_alu", alu_out_e, 32'd0);
    chk("nomd_multu_stall", 32'(stall_req), 32'd0);
    set_dec(4'hB, 32'd0, 32'd0, 1'b1, 5'd5);
    @(posedge clk); #1;
    chk("nomd_mfhi_alu", alu_out_e, 32'd0);
    chk("nomd_mfhi_stall", 32'(stall_req), 32'd0);
    chk("nomd_mfhi_rw", 32'(reg_write_e), 32'd1);
    set_dec(4'hE, 32'd100, 32'd7, 1'b0, 5'd0);
    @(posedge clk); #1;
    chk("nomd_divu_alu", alu_out_e, 32'd0);
    set_dec(4'hC, 32'd0, 32'd0, 1'b1, 5'd6);
    @(posedge clk); #1;
    chk("nomd_mflo_alu", alu_out_e, 32'd0);
    chk("nomd_mflo_stall", 32'(stall_req), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
